// File: rtl/data_mem.sv
// data_mem: word-organised 32-bit data memory, sync word writes, combinational reads; DMEM_ALIGN_CHECK_EN adds misaligned detection
module data_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] rdata
);
  logic [31:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic wr_ok;
  logic unused_addr;
  assign idx = addr[ADDR_BITS+1:2];
  assign unused_addr = ^{addr[31:ADDR_BITS+2], addr[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = addr[1:0] != 2'b00;
  assign wr_ok = we & ~misaligned;
`else
  assign wr_ok = we;
`endif
  // clear whole array on reset, otherwise capture a full word when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[idx] <= wdata;
    end
  end
  assign rdata = mem[idx];
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized scoreboard bench for data_mem against an array model
module tb_data_mem;
  localparam int WORDS = 1024;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] addr = '0;
  logic we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
`endif
  typedef struct {
    bit          chk;
    logic [31:0] a;
    logic [31:0] exp;
    bit          mis;
  } item_t;
  item_t q[$];
  logic [31:0] model [WORDS];
  int checks = 0;
  int failures = 0;
  data_mem #(.ADDR_BITS(10)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .we(we),
    .wdata(wdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .rdata(rdata)
  );
  always #5 clk = ~clk;
  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % WORDS;
  endfunction
  task automatic op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit chk);
    item_t it;
    bit mis;
    @(posedge clk);
    #1;
    rst = r;
    we = w;
    addr = a;
    wdata = d;
    mis = (a % 4) != 0;
    it.chk = chk;
    it.a = a;
    it.exp = model[widx(a)];
    it.mis = mis;
    q.push_back(it);
    if (r) begin
      for (int i = 0; i < WORDS; i++) model[i] = '0;
    end else if (w) begin
`ifdef DMEM_ALIGN_CHECK_EN
      if (!mis) model[widx(a)] = d;
`else
      model[widx(a)] = d;
`endif
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      if (it.chk) begin
        checks++;
        if (rdata !== it.exp) begin
          failures++;
          $display("FAIL rdata addr=%h got=%h exp=%h", it.a, rdata, it.exp);
        end
`ifdef DMEM_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== it.mis) begin
          failures++;
          $display("FAIL misaligned addr=%h got=%b exp=%b", it.a, misaligned, it.mis);
        end
`endif
      end
    end
  end
  initial begin
    int wait_cnt;
    op(1, 0, 32'h0, 32'h0, 0);
    op(0, 0, 32'h0, 32'h0, 1);
    op(0, 0, 32'hFFC, 32'h0, 1);
    op(0, 1, 32'h0, 32'hDEADBEEF, 1);
    op(0, 0, 32'h0, 32'h0, 1);
    op(0, 1, 32'h4, 32'hCAFEBABE, 1);
    op(0, 0, 32'h4, 32'h0, 1);
    op(0, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) op(0, 0, 32'h8, 32'h12345678, 1);
    op(0, 1, 32'h1000, 32'h0BADF00D, 1);
    op(0, 0, 32'h0, 32'h0, 1);
    op(0, 1, 32'h6, 32'h55AA55AA, 1);
    op(0, 0, 32'h4, 32'h0, 1);
    op(1, 1, 32'h4, 32'hFFFFFFFF, 1);
    op(0, 0, 32'h4, 32'h0, 1);
    op(0, 0, 32'h0, 32'h0, 1);
    op(0, 1, 32'h10, 32'h11111111, 1);
    op(0, 1, 32'h14, 32'h22222222, 1);
    op(0, 1, 32'h18, 32'h33333333, 1);
    op(0, 0, 32'h14, 32'h0, 1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      op($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, a, $urandom(), 1);
    end
    op(0, 0, 32'h0, 32'h0, 1);
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
